// File: rtl/dtree_seq_engine.sv
// -----------------------------------------------------------------------------
// dtree_seq_engine
//
// Serialised decision-tree classifier. A feature vector is captured on
// acceptance, then the engine walks a run-time programmable node table one
// node per clock using a single truncated-precision comparator, and presents
// the class label (or an abort flag) on a valid/ready output.
//
// Node word layout, MSB -> LSB:
//   leaf | feat_idx[FI_W] | shift[SH_W] | thr[FEAT_W] | left[PTR_W] | right[PTR_W]
// A leaf returns thr[CLASS_W-1:0]. A non-leaf compares
// (feat[feat_idx] >> shift) <= thr (unsigned) and follows left on true,
// right on false.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/addr/data    node-table write port (honoured only while idle)
//   in_valid/in_ready   feature-vector handshake
//   in_feat             N_FEAT packed features, feature i at [i*FEAT_W +: FEAT_W]
//   out_valid/out_ready result handshake
//   out_class           predicted class label
//   out_err             walk aborted (depth overrun or bad feature index)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that edge; ready may be driven independently of valid.
// -----------------------------------------------------------------------------
module dtree_seq_engine #(
  parameter int N_FEAT    = 45,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int DEPTH_MAX = 16,
  parameter int CLASS_W   = 5,
  // Derived widths: not intended to be overridden.
  localparam int FI_W   = (N_FEAT  > 1) ? $clog2(N_FEAT)  : 1,
  localparam int SH_W   = (FEAT_W  > 1) ? $clog2(FEAT_W)  : 1,
  localparam int PTR_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1,
  localparam int NODE_W = 1 + FI_W + SH_W + FEAT_W + 2 * PTR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [PTR_W-1:0]         cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err
);

  localparam int DEP_W = (DEPTH_MAX > 1) ? $clog2(DEPTH_MAX) : 1;

  // Field offsets inside a node word.
  localparam int RIGHT_LSB = 0;
  localparam int LEFT_LSB  = PTR_W;
  localparam int THR_LSB   = 2 * PTR_W;
  localparam int SH_LSB    = THR_LSB + FEAT_W;
  localparam int FI_LSB    = SH_LSB + SH_W;
  localparam int LEAF_BIT  = FI_LSB + FI_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  // FSM state, kept as a named enum signal so checkers can bind to it.
  state_t state;

  logic [NODE_W-1:0]        node_tbl [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] feat_q;
  logic [PTR_W-1:0]         ptr;
  logic [DEP_W-1:0]         depth;

  // ---------------------------------------------------------------------------
  // Node read and field decode
  // ---------------------------------------------------------------------------
  logic              ptr_ok;
  logic              addr_ok;
  logic [NODE_W-1:0] node_rd;
  logic              nd_leaf;
  logic [FI_W-1:0]   nd_fi;
  logic [SH_W-1:0]   nd_sh;
  logic [FEAT_W-1:0] nd_thr;
  logic [PTR_W-1:0]  nd_left;
  logic [PTR_W-1:0]  nd_right;

  // Pointers beyond the table (only possible for non-power-of-two N_NODES)
  // behave as an all-zero node.
  assign ptr_ok  = ({1'b0, ptr}      < (PTR_W+1)'(N_NODES));
  assign addr_ok = ({1'b0, cfg_addr} < (PTR_W+1)'(N_NODES));

  always_comb begin
    node_rd = '0;
    if (ptr_ok) begin
      node_rd = node_tbl[ptr];
    end
  end

  assign nd_leaf  = node_rd[LEAF_BIT];
  assign nd_fi    = node_rd[FI_LSB    +: FI_W];
  assign nd_sh    = node_rd[SH_LSB    +: SH_W];
  assign nd_thr   = node_rd[THR_LSB   +: FEAT_W];
  assign nd_left  = node_rd[LEFT_LSB  +: PTR_W];
  assign nd_right = node_rd[RIGHT_LSB +: PTR_W];

  // ---------------------------------------------------------------------------
  // Feature select and truncated compare
  // ---------------------------------------------------------------------------
  logic              fi_ok;
  logic [FEAT_W-1:0] feat_sel;
  logic [FEAT_W-1:0] feat_shr;
  logic              go_left;
  logic              depth_last;

  assign fi_ok = ({1'b0, nd_fi} < (FI_W+1)'(N_FEAT));

  // Explicit mux keeps the out-of-range index case well defined (selects 0).
  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (nd_fi == FI_W'(i)) begin
        feat_sel = feat_q[i*FEAT_W +: FEAT_W];
      end
    end
  end

  // Right-shifting drops the low bits, so only the top FEAT_W-shift bits of
  // the feature take part in the compare.
  assign feat_shr   = feat_sel >> nd_sh;
  assign go_left    = (feat_shr <= nd_thr);
  assign depth_last = (depth == DEP_W'(DEPTH_MAX - 1));

  // ---------------------------------------------------------------------------
  // Node table: writes only while idle, so a walk always sees a stable tree.
  // A write on the acceptance edge lands before the first node read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) begin
        node_tbl[i] <= '0;
      end
    end else if (cfg_we && (state == IDLE) && addr_ok) begin
      node_tbl[cfg_addr] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      feat_q    <= '0;
      ptr       <= '0;
      depth     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            feat_q   <= in_feat;
            ptr      <= '0;
            depth    <= '0;
            in_ready <= 1'b0;
            state    <= WALK;
          end
        end

        WALK: begin
          if (nd_leaf) begin
            out_class <= nd_thr[CLASS_W-1:0];
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!fi_ok || depth_last) begin
            // Abort: bad feature index, or the walk would exceed DEPTH_MAX.
            out_class <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            ptr   <= go_left ? nd_left : nd_right;
            depth <= depth + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// -----------------------------------------------------------------------------
// tb_dtree_seq_engine
//
// Directed bench for dtree_seq_engine at default parameters. Expected results
// ({latency, err, class}) are queued when a vector is accepted and popped
// when out_valid is observed. Latency is counted in rising edges from the
// acceptance edge to the edge after which out_valid is high (leaf at depth d
// gives d+1).
// -----------------------------------------------------------------------------
module tb_dtree_seq_engine;

  localparam int N_FEAT    = 45;
  localparam int FEAT_W    = 8;
  localparam int N_NODES   = 64;
  localparam int DEPTH_MAX = 16;
  localparam int CLASS_W   = 5;
  localparam int PTR_W     = 6;
  localparam int NODE_W    = 30;
  localparam int FV_W      = N_FEAT * FEAT_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [PTR_W-1:0]  cfg_addr;
  logic [NODE_W-1:0] cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [FV_W-1:0]   in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CLASS_W-1:0] out_class;
  logic              out_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dtree_seq_engine #(
    .N_FEAT    (N_FEAT),
    .FEAT_W    (FEAT_W),
    .N_NODES   (N_NODES),
    .DEPTH_MAX (DEPTH_MAX),
    .CLASS_W   (CLASS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cyc  = 0;
  logic [13:0] exp_q[$];   // {lat[7:0], err, class[4:0]}

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk_node(input logic leaf,
      input logic [5:0] fi, input logic [2:0] sh, input logic [7:0] thr,
      input logic [5:0] l, input logic [5:0] r);
    return {leaf, fi, sh, thr, l, r};
  endfunction

  function automatic logic [NODE_W-1:0] leaf_node(input logic [7:0] cls);
    return mk_node(1'b1, 6'd0, 3'd0, cls, 6'd0, 6'd0);
  endfunction

  // Vector with every feature at `fill` except feature idx set to val.
  function automatic logic [FV_W-1:0] mk_vec(input int idx, input logic [7:0] val,
                                             input logic [7:0] fill);
    logic [FV_W-1:0] v;
    for (int i = 0; i < N_FEAT; i++) v[i*FEAT_W +: FEAT_W] = fill;
    v[idx*FEAT_W +: FEAT_W] = val;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cfg_write(input logic [PTR_W-1:0] addr, input logic [NODE_W-1:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_vec(input logic [FV_W-1:0] feat, input int lat,
                          input logic err, input logic [4:0] cls);
    @(negedge clk);
    check_eq("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_feat  = feat;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    exp_q.push_back({lat[7:0], err, cls});
  endtask

  task automatic wait_result(input string tag);
    int          guard;
    logic [13:0] e;
    guard = 0;
    while (!out_valid && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq({tag, "_no_timeout"}, (guard < 60), 1);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_exp_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_latency"}, cyc - acc_cyc, e[13:6]);
      check_eq({tag, "_err"},     out_err,       e[5]);
      check_eq({tag, "_class"},   out_class,     e[4:0]);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_dropped"}, out_valid, 0);
    check_eq({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] x2_tbl  [6] = '{8'h60, 8'h80, 8'h7F, 8'h9F, 8'h00, 8'hFF};
  logic [4:0] cls_tbl [6] = '{5'd13, 5'd3, 5'd13, 5'd3, 5'd13, 5'd3};

  initial begin
    logic seen;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;

    // Reset values
    #12;
    check_eq("rst_in_ready",  in_ready,  1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_class", out_class, 0);
    check_eq("rst_out_err",   out_err,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unprogrammed table: all-zero nodes loop to node 0 until depth abort.
    send_vec('0, DEPTH_MAX, 1'b1, 5'd0);
    wait_result("unprog");
    consume("unprog");

    // Basic tree: node0 compares feature 2 bits [7:5] against 3.
    cfg_write(0, mk_node(1'b0, 6'd2, 3'd5, 8'd3, 6'd1, 6'd2));
    cfg_write(1, leaf_node(8'd13));
    cfg_write(2, leaf_node(8'd3));
    for (int i = 0; i < 6; i++) begin
      send_vec(mk_vec(2, x2_tbl[i], 8'hA5), 2, 1'b0, cls_tbl[i]);
      wait_result($sformatf("tree_x2_%0h", x2_tbl[i]));
      consume("tree");
    end

    // Backpressure: result held, no new acceptance while out_ready is low.
    send_vec(mk_vec(2, 8'h60, 8'h00), 2, 1'b0, 5'd13);
    wait_result("hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_feat  = mk_vec(2, 8'h80, 8'h00);
      @(posedge clk);
      #1;
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_out_class", out_class, 13);
      check_eq("hold_out_err",   out_err,   0);
      check_eq("hold_in_ready",  in_ready,  0);
    end
    in_valid = 1'b0;
    consume("hold");
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("hold_no_extra_result", seen, 0);

    // Config write during WALK is ignored.
    send_vec(mk_vec(2, 8'h60, 8'h00), 2, 1'b0, 5'd13);
    cfg_we   = 1'b1;
    cfg_addr = 6'd1;
    cfg_data = leaf_node(8'd7);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_result("walk_write_ignored");
    consume("walk_write");

    // The same write in IDLE takes effect.
    cfg_write(1, leaf_node(8'd7));
    send_vec(mk_vec(2, 8'h60, 8'h00), 2, 1'b0, 5'd7);
    wait_result("idle_write");
    consume("idle_write");

    // Write and acceptance on the same edge: walk sees the new node.
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = mk_vec(2, 8'h60, 8'h00);
    cfg_we   = 1'b1;
    cfg_addr = 6'd1;
    cfg_data = leaf_node(8'd9);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    exp_q.push_back({8'd2, 1'b0, 5'd9});
    wait_result("same_edge_write");
    consume("same_edge");

    // Feature index bounds: 50 and 45 abort at the root, 44 is valid.
    cfg_write(0, mk_node(1'b0, 6'd50, 3'd0, 8'd0, 6'd1, 6'd2));
    send_vec(mk_vec(2, 8'h60, 8'h00), 1, 1'b1, 5'd0);
    wait_result("fi_50");
    consume("fi_50");
    cfg_write(0, mk_node(1'b0, 6'd45, 3'd0, 8'd0, 6'd1, 6'd2));
    send_vec('0, 1, 1'b1, 5'd0);
    wait_result("fi_45");
    consume("fi_45");
    cfg_write(0, mk_node(1'b0, 6'd44, 3'd0, 8'h10, 6'd1, 6'd2));
    send_vec(mk_vec(44, 8'h10, 8'hFF), 2, 1'b0, 5'd9);
    wait_result("fi_44_left");
    consume("fi_44");
    send_vec(mk_vec(44, 8'h11, 8'h00), 2, 1'b0, 5'd3);
    wait_result("fi_44_right");
    consume("fi_44");

    // Depth boundary: chain 0->1->...->15. Leaf at depth 15 is fine,
    // a non-leaf there aborts.
    for (int i = 0; i < 15; i++) begin
      cfg_write(PTR_W'(i), mk_node(1'b0, 6'd0, 3'd0, 8'hFF, 6'(i + 1), 6'(i + 1)));
    end
    cfg_write(15, leaf_node(8'd21));
    send_vec('0, DEPTH_MAX, 1'b0, 5'd21);
    wait_result("depth15_leaf");
    consume("depth15_leaf");
    cfg_write(15, mk_node(1'b0, 6'd0, 3'd0, 8'hFF, 6'd16, 6'd16));
    send_vec('0, DEPTH_MAX, 1'b1, 5'd0);
    wait_result("depth_overrun");
    consume("depth_overrun");

    // Reset mid-walk: no result, back to idle, table cleared.
    send_vec('0, DEPTH_MAX, 1'b1, 5'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready",  in_ready,  1);
    check_eq("midrst_out_valid", out_valid, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("midrst_no_result", seen, 0);
    check_eq("midrst_idle_ready", in_ready, 1);
    send_vec(mk_vec(2, 8'h60, 8'h00), DEPTH_MAX, 1'b1, 5'd0);
    wait_result("after_reset_cleared");
    consume("after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dtree_seq_engine.md
# dtree_seq_engine

Programmable, serialised decision-tree classifier: the next generation of the team's printed-electronics tree blocks. It replaces a fixed combinational comparator tree with a single truncated-precision comparator that walks a node table one node per cycle. Feature count, feature width, table depth and class width are all parameters, and the tree is loaded at run time through a config port. It sits between the feature-quantisation front end and the class-output register, with valid/ready on both sides.

## Interface
- N_FEAT, 45: number of input features
- FEAT_W, 8: bits per feature; also threshold width
- N_NODES, 64: node-table entries
- DEPTH_MAX, 16: maximum nodes visited per inference
- CLASS_W, 5: class label width; must be ≤ FEAT_W
- Derived, not overridable:
  - FI_W = clog2(N_FEAT)
  - SH_W = clog2(FEAT_W)
  - PTR_W = clog2(N_NODES)
  - NODE_W = 1+FI_W+SH_W+FEAT_W+2*PTR_W
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  PTR_W  node index to write
- cfg_data  in  NODE_W  node word, MSB→LSB:
  - leaf
  - feat_idx
  - shift
  - thr
  - left
  - right
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine can accept a vector
- in_feat  in  N_FEAT*FEAT_W  features; feature i is bits [i*FEAT_W +: FEAT_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLASS_W  predicted class
- out_err  out  1  inference aborted (depth overrun or bad feature index)

## Operation
- States:
  - IDLE: in_ready=1
  - WALK
  - DONE: out_valid=1
- IDLE → WALK on in_valid && in_ready:
  - in_feat captured into an internal register
  - ptr ← 0
  - depth ← 0
- WALK, one node per cycle, reading node[ptr]:
  - leaf=1: out_class ← thr[CLASS_W-1:0], out_err ← 0, → DONE.
  - leaf=0, feat_idx ≥ N_FEAT: out_class ← 0, out_err ← 1, → DONE.
  - leaf=0, depth == DEPTH_MAX-1: out_class ← 0, out_err ← 1, → DONE.
  - Otherwise compare unsigned (feat[feat_idx] >> shift) <= thr. True: ptr ← left, else ptr ← right. depth ← depth+1.
- The shift reproduces MSB-truncated comparisons: shift=5 compares bits [7:5] only.
- DONE: out_class and out_err held stable; → IDLE on out_ready.
- in_feat is sampled only at acceptance; changes during WALK/DONE have no effect.
- Config writes are honoured only in IDLE. cfg_we in WALK/DONE is ignored; no write occurs.
- A write in IDLE on the same edge as vector acceptance completes before the walk reads the table.
- Node table is registers, cleared to all-zero by reset. An all-zero node is a non-leaf looping to node 0, so an unprogrammed engine always returns out_err=1 after DEPTH_MAX cycles.
- ptr values ≥ N_NODES (non-power-of-two N_NODES) read as an all-zero node.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE
  - in_ready=1, out_valid=0, out_class=0, out_err=0
  - ptr=0, depth=0
  - table cleared
- Vector accepted at edge t: cycle t+1 evaluates the root (depth 0). A leaf at depth d is evaluated in cycle t+1+d. out_valid is high from cycle t+2+d.
- Latency from acceptance to out_valid = d+2 cycles.
- Worst case DEPTH_MAX+1 cycles, for error aborts.
- out_valid && out_ready at edge u: in_ready=1 from cycle u+1. Minimum initiation interval d+3 cycles.
- Reset asserted mid-WALK or mid-DONE: immediate return to IDLE. Pending result discarded; no out_valid pulse.
- out_valid never deasserts without out_ready; out_class and out_err are constant while out_valid=1.

## Test plan
- Reset, no config; accept vector at t → out_valid at t+DEPTH_MAX+1, out_err=1, out_class=0.
- Program the table (default params):
  - node0 = {feat 2, shift 5, thr 3, left 1, right 2}
  - node1 = leaf class 13
  - node2 = leaf class 3
  - X2=0x60 → out_class=13, out_err=0, out_valid at t+3.
  - X2=0x80 → out_class=3.
- Same table, hold out_ready=0 for 10 cycles:
  - out_valid and out_class stay constant
  - in_ready=0 throughout
  - in_valid pulses are not accepted.
- cfg_we writing node1 = leaf class 7 during WALK → result still 13. The same write in IDLE → next inference returns 7.
- Node0 with feat_idx=50 (≥45) → out_err=1, out_class=0 at t+2.
- Assert rst_n low during WALK → out_valid never rises, in_ready=1, table cleared (next inference errors).
